fft_result_reader: RTL and testbench

FFT_RESULT_READER -- requirements
Module: fft_result_reader

---
 rtl/fft_result_reader_if.sv | 31 +++
 rtl/fft_result_reader.sv | 136 +++++++++++++
 tb/tb_fft_result_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_reader_if.sv
// Read-side memory port and result stream of the FFT result reader.
// The master modport is the reader's side; the slave modport is the memory and downstream side.
interface fft_result_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
);
  logic              mem_select;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_data;

  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_select, mem_address, mem_read_en,
    input  mem_data,
    output out_data, out_index, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_select, mem_address, mem_read_en,
    output mem_data,
    input  out_data, out_index, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_result_reader.sv
// Unloads a finished transform from the two-bank memory and streams it in natural index order.
// A 3-entry skid FIFO absorbs the one-cycle read latency so reads never depend on out_ready.
module fft_result_reader #(
  parameter int unsigned N_POINTS    = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 64,
  parameter bit          BIT_REVERSE = 1'b0
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                fft_done,
  input  logic                bank_in,
  fft_result_reader_if.master bus,
  output logic                busy,
  output logic                unload_done
);

  localparam int unsigned Depth = 3;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_idx_q;

  logic [DATA_W-1:0] fifo_data_q [Depth];
  logic [ADDR_W-1:0] fifo_idx_q  [Depth];
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;

  logic              issue, push, pop, head_last;
  logic [ADDR_W-1:0] last_idx, issue_addr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign last_idx = ADDR_W'(N_POINTS - 1);

  // Occupancy plus the read in flight bounds what can land next cycle, so a push never
  // meets a full FIFO even if nothing is popped in between.
  assign issue = (state_q == StRead) && (({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2);
  assign push  = inflight_q;
  assign pop   = bus.out_valid && bus.out_ready;

  always_comb begin
    issue_addr = issue_cnt_q;
    if (BIT_REVERSE) begin
      for (int i = 0; i < int'(ADDR_W); i++) begin
        issue_addr[i] = issue_cnt_q[int'(ADDR_W) - 1 - i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    issue_cnt_d = issue_cnt_q;
    unload_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fft_done) begin
          state_d     = StRead;
          sel_d       = bank_in;
          issue_cnt_d = '0;
        end
      end
      StRead: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + ADDR_W'(1);
          if (issue_cnt_q == last_idx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && head_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        unload_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q        <= StIdle;
      sel_q          <= 1'b0;
      issue_cnt_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      wr_ptr_q       <= 2'd0;
      rd_ptr_q       <= 2'd0;
      count_q        <= 2'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= issue;
      if (issue) begin
        inflight_idx_q <= issue_cnt_q;
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (clr_n && push) begin
      fifo_data_q[wr_ptr_q] <= bus.mem_data;
      fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
    end
  end

  assign head_last       = (fifo_idx_q[rd_ptr_q] == last_idx);
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_data    = bus.out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_index   = bus.out_valid ? fifo_idx_q[rd_ptr_q] : '0;
  assign bus.out_last    = bus.out_valid && head_last;
  assign bus.mem_select  = sel_q;
  assign bus.mem_address = issue_addr;
  assign bus.mem_read_en = issue;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_fft_result_reader.sv
// Drives a natural-order and a bit-reversed reader side by side from one stimulus stream and
// scoreboards both streams against a list of expected words built when each transform starts.
module tb_fft_result_reader;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] index;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic fft_done = 1'b0;
  logic bank_in = 1'b0;
  logic out_ready = 1'b0;
  logic exp_sel = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int fft_cyc = 0;

  logic [DW-1:0] mem [2][N];
  exp_t exp_q [2][$];
  int issued [2];
  int popped [2];
  int acc_cnt [2];
  int done_cnt [2];
  int first_cyc [2];
  int last_cyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
    return {<<{k}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic busy;
    logic unload_done;
    exp_t e;

    fft_result_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fft_result_reader #(
      .N_POINTS   (N),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .BIT_REVERSE(g == 1)
    ) u_dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .fft_done   (fft_done),
      .bank_in    (bank_in),
      .bus        (bus),
      .busy       (busy),
      .unload_done(unload_done)
    );

    assign bus.out_ready = out_ready;

    always @(posedge clk) begin
      if (bus.mem_read_en) bus.mem_data <= mem[bus.mem_select][bus.mem_address];
    end

    always @(negedge clk) begin
      if (clr_n) begin
        if (bus.mem_read_en) begin
          check($sformatf("no_fifo_overflow_%0d", g), 128'(issued[g] - popped[g] <= 2), 128'(1));
          issued[g]++;
        end
        if (busy) check($sformatf("mem_select_%0d", g), 128'(bus.mem_select), 128'(exp_sel));
        if (bus.out_valid) begin
          if (first_cyc[g] < 0) first_cyc[g] = cyc;
          check($sformatf("word_expected_%0d", g), 128'(exp_q[g].size() != 0), 128'(1));
          if (exp_q[g].size() != 0) begin
            e = exp_q[g][0];
            check($sformatf("word_%0d_idx%0d", g, e.index),
                  128'({bus.out_data, bus.out_index, bus.out_last}),
                  128'({e.data, e.index, e.index == AW'(N - 1)}));
            if (out_ready) begin
              void'(exp_q[g].pop_front());
              popped[g]++;
              acc_cnt[g]++;
              last_cyc[g] = cyc;
            end
          end
        end
        if (unload_done) begin
          done_cnt[g]++;
          check($sformatf("done_after_last_%0d", g), 128'(exp_q[g].size()), 128'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_expected(input logic bank);
    exp_t e;
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < 2; i++) begin
        e.index = AW'(k);
        e.data  = mem[bank][(i == 1) ? bitrev(AW'(k)) : AW'(k)];
        exp_q[i].push_back(e);
      end
    end
  endtask

  task automatic randomize_mem();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < int'(N); a++) mem[b][a] = {$urandom, $urandom};
  endtask

  task automatic check_reset_values();
    check("reset_outputs_0", 128'({g_dut[0].bus.out_valid, g_dut[0].bus.out_last, g_dut[0].busy,
          g_dut[0].unload_done, g_dut[0].bus.mem_read_en, g_dut[0].bus.mem_address,
          g_dut[0].bus.mem_select, g_dut[0].bus.out_data, g_dut[0].bus.out_index}), 128'(0));
    check("reset_outputs_1", 128'({g_dut[1].bus.out_valid, g_dut[1].bus.out_last, g_dut[1].busy,
          g_dut[1].unload_done, g_dut[1].bus.mem_read_en, g_dut[1].bus.mem_address,
          g_dut[1].bus.mem_select, g_dut[1].bus.out_data, g_dut[1].bus.out_index}), 128'(0));
  endtask

  task automatic start_transform(input logic bank);
    for (int i = 0; i < 2; i++) first_cyc[i] = -1;
    push_expected(bank);
    exp_sel  = bank;
    bank_in  = bank;
    fft_done = 1'b1;
    fft_cyc  = cyc;
  endtask

  task automatic run_transform(input logic bank, input bit rnd_ready, input bit toggle_bank,
                               input bit double_pulse);
    int d0 [2];
    bit finished;
    for (int i = 0; i < 2; i++) d0[i] = done_cnt[i];
    start_transform(bank);
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    fft_done = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done_cnt[0] != d0[0] && done_cnt[1] != d0[1]) begin
        finished = 1'b1;
        break;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle_bank) bank_in = 1'($urandom_range(0, 1));
      if (double_pulse && c == 4) begin
        bank_in  = ~bank;
        fft_done = 1'b1;
      end else begin
        fft_done = 1'b0;
      end
      tick();
    end
    fft_done = 1'b0;
    check("transform_finished", 128'(finished), 128'(1));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("unload_done_count_%0d", i), 128'(done_cnt[i] - d0[i]), 128'(1));
      check($sformatf("words_left_%0d", i), 128'(exp_q[i].size()), 128'(0));
      check($sformatf("first_valid_latency_%0d", i), 128'(first_cyc[i] - fft_cyc >= 2), 128'(1));
    end
    if (!rnd_ready) check("throughput_span", 128'(last_cyc[0] - first_cyc[0] + 1), 128'(N));
    repeat (4) tick();
    check("idle_after_done", 128'({g_dut[0].busy, g_dut[1].busy, g_dut[0].bus.out_valid}), 128'(0));
    check("single_unload_done", 128'(done_cnt[0] - d0[0]), 128'(1));
  endtask

  initial begin
    int a0;
    bit reached;
    for (int i = 0; i < 2; i++) begin
      issued[i] = 0; popped[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0;
      first_cyc[i] = -1; last_cyc[i] = 0;
    end
    for (int a = 0; a < int'(N); a++) begin
      mem[0][a] = DW'(a);
      mem[1][a] = 64'hB1B1_0000_0000_0000 | DW'(a);
    end

    clr_n = 1'b0;
    tick();
    tick();
    check_reset_values();
    clr_n = 1'b1;
    tick();

    // Address-valued preload, free-flowing sink.
    run_transform(1'b0, 1'b0, 1'b0, 1'b0);

    // Random stalls with bank_in wandering after the start pulse.
    randomize_mem();
    run_transform(1'b1, 1'b1, 1'b1, 1'b0);

    // A second start pulse mid-unload must be ignored.
    randomize_mem();
    run_transform(1'b0, 1'b1, 1'b0, 1'b1);

    // Abort after index 10 has been accepted.
    randomize_mem();
    a0 = acc_cnt[0];
    start_transform(1'b1);
    tick();
    fft_done = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (acc_cnt[0] - a0 >= 11) begin
        reached = 1'b1;
        break;
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("abort_point_reached", 128'(reached), 128'(1));
    out_ready = 1'b0;
    clr_n = 1'b0;
    tick();
    check_reset_values();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      issued[i] = 0;
      popped[i] = 0;
    end
    tick();
    clr_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("no_words_after_abort", 128'({g_dut[0].bus.out_valid, g_dut[1].bus.out_valid}), 128'(0));
    run_transform(1'b1, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      randomize_mem();
      run_transform(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
